// File: rtl/pipe_hazard_ctrl.sv
// Sequencing, forwarding and write-back stall control for the 8-bit shift/move pipeline.
// Enables are decoded from State and the current hazard; forwarding selects are registered.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_BITS    = 3,
  parameter int unsigned FILL_CYCLES = 2,
  parameter int unsigned CNT_BITS    = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Hold_Req,
  input  logic                Cnt_Clr,
  input  logic [REG_BITS-1:0] ID_Rs1,
  input  logic                ID_Rs1_Vld,
  input  logic [REG_BITS-1:0] ID_Rs2,
  input  logic                ID_Rs2_Vld,
  input  logic                ID_EX_RegWrite,
  input  logic [REG_BITS-1:0] ID_EX_Write_Reg_Num,
  input  logic                ID_EX_SMCtrl,
  input  logic                EX_WB_RegWrite,
  input  logic [REG_BITS-1:0] EX_WB_Write_Reg_Num,
  output logic                PC_En,
  output logic                IF_ID_En,
  output logic                ID_EX_Bubble,
  output logic                WB_En,
  output logic [1:0]          FwdCtrlA,
  output logic [1:0]          FwdCtrlB,
  output logic [1:0]          State,
  output logic [CNT_BITS-1:0] Stall_Count
);

  localparam int unsigned FILL_W = 4;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FILL = 2'b01,
    S_RUN  = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t            state_q;
  logic [FILL_W-1:0] fill_cnt_q;

  logic run;
  logic rs1_ex_match;
  logic rs2_ex_match;
  logic rs1_wb_haz;
  logic rs2_wb_haz;
  logic wb_stall;
  logic fwd_ok;
  logic [1:0] fwd_sel;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  assign State = state_q;

  // Hazard and forwarding decode; the newer EX producer shadows the WB producer
  always_comb begin
    run          = (state_q == S_RUN);
    rs1_ex_match = ID_Rs1_Vld && ID_EX_RegWrite && (ID_Rs1 == ID_EX_Write_Reg_Num);
    rs2_ex_match = ID_Rs2_Vld && ID_EX_RegWrite && (ID_Rs2 == ID_EX_Write_Reg_Num);
    rs1_wb_haz   = ID_Rs1_Vld && (ID_Rs1 == EX_WB_Write_Reg_Num) && !rs1_ex_match;
    rs2_wb_haz   = ID_Rs2_Vld && (ID_Rs2 == EX_WB_Write_Reg_Num) && !rs2_ex_match;
    wb_stall     = run && EX_WB_RegWrite && (rs1_wb_haz || rs2_wb_haz);
    fwd_ok       = run && !wb_stall;
    fwd_sel      = ID_EX_SMCtrl ? 2'b10 : 2'b11;
    fwd_a_d      = (fwd_ok && rs1_ex_match) ? fwd_sel : 2'b00;
    fwd_b_d      = (fwd_ok && rs2_ex_match) ? fwd_sel : 2'b00;
  end

  // Pipeline enable decode from state and hazard
  always_comb begin
    PC_En        = 1'b0;
    IF_ID_En     = 1'b0;
    ID_EX_Bubble = 1'b1;
    WB_En        = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FILL: begin
        PC_En    = 1'b1;
        IF_ID_En = 1'b1;
      end
      S_RUN: begin
        PC_En        = !wb_stall;
        IF_ID_En     = !wb_stall;
        ID_EX_Bubble = wb_stall;
        WB_En        = 1'b1;
      end
      S_HOLD: WB_En = 1'b1;
      default: ;
    endcase
  end

  // State machine, fill counter, forwarding registers and stall counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      fill_cnt_q  <= '0;
      FwdCtrlA    <= 2'b00;
      FwdCtrlB    <= 2'b00;
      Stall_Count <= '0;
    end else begin
      FwdCtrlA <= fwd_a_d;
      FwdCtrlB <= fwd_b_d;

      unique case (state_q)
        S_IDLE: begin
          fill_cnt_q <= '0;
          state_q    <= S_FILL;
        end
        S_FILL: begin
          if (fill_cnt_q == FILL_LAST) begin
            state_q <= S_RUN;
          end else begin
            fill_cnt_q <= fill_cnt_q + FILL_W'(1);
          end
        end
        S_RUN: begin
          if (Hold_Req) state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (!Hold_Req) state_q <= S_RUN;
        end
        default: state_q <= S_IDLE;
      endcase

      if (Cnt_Clr) begin
        Stall_Count <= '0;
      end else if (((state_q == S_HOLD) || wb_stall) && !(&Stall_Count)) begin
        Stall_Count <= Stall_Count + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic       Clk;
  logic       Reset;
  logic       Hold_Req;
  logic       Cnt_Clr;
  logic [2:0] ID_Rs1;
  logic       ID_Rs1_Vld;
  logic [2:0] ID_Rs2;
  logic       ID_Rs2_Vld;
  logic       ID_EX_RegWrite;
  logic [2:0] ID_EX_Write_Reg_Num;
  logic       ID_EX_SMCtrl;
  logic       EX_WB_RegWrite;
  logic [2:0] EX_WB_Write_Reg_Num;
  logic       PC_En;
  logic       IF_ID_En;
  logic       ID_EX_Bubble;
  logic       WB_En;
  logic [1:0] FwdCtrlA;
  logic [1:0] FwdCtrlB;
  logic [1:0] State;
  logic [7:0] Stall_Count;

  int n_asserts = 0;
  int n_fails   = 0;

  pipe_hazard_ctrl #(
    .REG_BITS(3),
    .FILL_CYCLES(2),
    .CNT_BITS(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Hold_Req(Hold_Req),
    .Cnt_Clr(Cnt_Clr),
    .ID_Rs1(ID_Rs1),
    .ID_Rs1_Vld(ID_Rs1_Vld),
    .ID_Rs2(ID_Rs2),
    .ID_Rs2_Vld(ID_Rs2_Vld),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_Write_Reg_Num(ID_EX_Write_Reg_Num),
    .ID_EX_SMCtrl(ID_EX_SMCtrl),
    .EX_WB_RegWrite(EX_WB_RegWrite),
    .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num),
    .PC_En(PC_En),
    .IF_ID_En(IF_ID_En),
    .ID_EX_Bubble(ID_EX_Bubble),
    .WB_En(WB_En),
    .FwdCtrlA(FwdCtrlA),
    .FwdCtrlB(FwdCtrlB),
    .State(State),
    .Stall_Count(Stall_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs1 = 3'd0; ID_Rs1_Vld = 1'b0;
    ID_Rs2 = 3'd0; ID_Rs2_Vld = 1'b0;
    ID_EX_RegWrite = 1'b0; ID_EX_Write_Reg_Num = 3'd0; ID_EX_SMCtrl = 1'b0;
    EX_WB_RegWrite = 1'b0; EX_WB_Write_Reg_Num = 3'd0;
  endtask

  task automatic check_enables(input string tag, input logic pc, input logic ifid,
                               input logic bub, input logic wb);
    check({tag, "_pc_en"},  8'(PC_En),        8'(pc));
    check({tag, "_ifid_en"}, 8'(IF_ID_En),    8'(ifid));
    check({tag, "_bubble"}, 8'(ID_EX_Bubble), 8'(bub));
    check({tag, "_wb_en"},  8'(WB_En),        8'(wb));
  endtask

  initial begin
    Reset = 1'b1; Hold_Req = 1'b0; Cnt_Clr = 1'b0;
    clear_inputs();
    // Hazard-looking inputs during reset must not disturb anything
    EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd1; ID_Rs1 = 3'd1; ID_Rs1_Vld = 1'b1;
    step(); step();
    check("rst_state", 8'(State), 8'h0);
    check_enables("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_fwda", 8'(FwdCtrlA), 8'h0);
    check("rst_fwdb", 8'(FwdCtrlB), 8'h0);
    check("rst_cnt", Stall_Count, 8'd0);

    // Start-up: IDLE -> FILL -> FILL -> RUN
    clear_inputs();
    Reset = 1'b0;
    #1;
    check("idle_state", 8'(State), 8'h0);
    step();
    check("fill1_state", 8'(State), 8'h1);
    check_enables("fill1", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("fill2_state", 8'(State), 8'h1);
    step();
    check("run_state", 8'(State), 8'h2);
    check_enables("run", 1'b1, 1'b1, 1'b0, 1'b1);

    // Forward shift result to operand A
    ID_EX_RegWrite = 1'b1; ID_EX_Write_Reg_Num = 3'd3; ID_EX_SMCtrl = 1'b1;
    ID_Rs1 = 3'd3; ID_Rs1_Vld = 1'b1; ID_Rs2 = 3'd4; ID_Rs2_Vld = 1'b1;
    #1;
    check("fwd_shift_pc_en", 8'(PC_En), 8'h1);
    step();
    check("fwd_shift_a", 8'(FwdCtrlA), 8'h2);
    check("fwd_shift_b", 8'(FwdCtrlB), 8'h0);
    check("fwd_shift_cnt", Stall_Count, 8'd0);

    // Rs1 == Rs2, move result forwarded to both
    ID_EX_Write_Reg_Num = 3'd5; ID_EX_SMCtrl = 1'b0;
    ID_Rs1 = 3'd5; ID_Rs2 = 3'd5;
    step();
    check("fwd_move_a", 8'(FwdCtrlA), 8'h3);
    check("fwd_move_b", 8'(FwdCtrlB), 8'h3);

    // Register 0 forwards like any other register
    ID_EX_Write_Reg_Num = 3'd0; ID_Rs1_Vld = 1'b0; ID_Rs2 = 3'd0;
    step();
    check("fwd_r0_a", 8'(FwdCtrlA), 8'h0);
    check("fwd_r0_b", 8'(FwdCtrlB), 8'h3);

    // WB read hazard on Rs2: one stall cycle
    clear_inputs();
    EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd2; ID_Rs2 = 3'd2; ID_Rs2_Vld = 1'b1;
    #1;
    check_enables("haz", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("haz_cnt", Stall_Count, 8'd1);
    check("haz_fwdb", 8'(FwdCtrlB), 8'h0);
    EX_WB_RegWrite = 1'b0;
    #1;
    check_enables("haz_after", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("haz_after_cnt", Stall_Count, 8'd1);

    // Newer EX producer shadows WB producer: forward, no stall
    EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd4;
    ID_EX_RegWrite = 1'b1; ID_EX_Write_Reg_Num = 3'd4; ID_EX_SMCtrl = 1'b1;
    ID_Rs1 = 3'd4; ID_Rs1_Vld = 1'b1; ID_Rs2_Vld = 1'b0;
    #1;
    check("shadow_pc_en", 8'(PC_En), 8'h1);
    step();
    check("shadow_fwda", 8'(FwdCtrlA), 8'h2);
    check("shadow_cnt", Stall_Count, 8'd1);

    // Hold request: current cycle still RUN, then 3 HOLD cycles
    clear_inputs();
    Hold_Req = 1'b1;
    #1;
    check("hold_req_run_pc_en", 8'(PC_En), 8'h1);
    step();
    check("hold1_state", 8'(State), 8'h3);
    check_enables("hold", 1'b0, 1'b0, 1'b1, 1'b1);
    EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd2; ID_Rs2 = 3'd2; ID_Rs2_Vld = 1'b1;
    ID_EX_RegWrite = 1'b1; ID_EX_Write_Reg_Num = 3'd1; ID_EX_SMCtrl = 1'b1;
    ID_Rs1 = 3'd1; ID_Rs1_Vld = 1'b1;
    #1;
    check("hold_haz_pc_en", 8'(PC_En), 8'h0);
    step();
    check("hold2_state", 8'(State), 8'h3);
    check("hold2_fwda", 8'(FwdCtrlA), 8'h0);
    check("hold2_cnt", Stall_Count, 8'd2);
    step();
    check("hold3_cnt", Stall_Count, 8'd3);
    Hold_Req = 1'b0;
    step();
    check("resume_state", 8'(State), 8'h2);
    check("resume_cnt", Stall_Count, 8'd4);
    check("resume_fwda", 8'(FwdCtrlA), 8'h0);
    check("resume_haz_pc_en", 8'(PC_En), 8'h0);
    clear_inputs();
    #1;
    check("resume_clr_pc_en", 8'(PC_En), 8'h1);

    // Asynchronous reset in the middle of HOLD
    Hold_Req = 1'b1;
    step();
    check("pre_rst_state", 8'(State), 8'h3);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_state", 8'(State), 8'h0);
    check("async_rst_cnt", Stall_Count, 8'd0);
    check("async_rst_wb_en", 8'(WB_En), 8'h0);
    step();
    Reset = 1'b0;
    step(); step(); step();
    check("rerun_state", 8'(State), 8'h2);

    // Saturation: first step enters HOLD, each further step adds one
    for (int i = 0; i < 256; i++) step();
    check("sat_255", Stall_Count, 8'd255);
    for (int i = 0; i < 5; i++) step();
    check("sat_hold", Stall_Count, 8'd255);
    Cnt_Clr = 1'b1;
    step();
    check("clr_cnt", Stall_Count, 8'd0);
    Cnt_Clr = 1'b0;
    step();
    check("post_clr_cnt", Stall_Count, 8'd1);
    Hold_Req = 1'b0;
    step();
    check("final_state", 8'(State), 8'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
